// File: rtl/gaussian_fir_pkg.sv
// Shared constants, coefficient type and Gaussian kernel for the 29-tap smoothing FIR.
// The kernel is Q8 and sums to 256, so the filter has unity DC gain.
package gaussian_fir_pkg;

   localparam int NCOEFS_FIXED = 29;
   localparam int COEF_WIDTH   = 16;
   localparam int COEF_FRAC    = 8;

   typedef logic signed [COEF_WIDTH-1:0] coef_t;

   localparam coef_t GAUSS_COEFS [0:NCOEFS_FIXED-1] = '{
      16'sd0,  16'sd0,  16'sd0,  16'sd1,  16'sd1,  16'sd2,  16'sd3,  16'sd6,
      16'sd8,  16'sd12, 16'sd15, 16'sd19, 16'sd23, 16'sd25, 16'sd26, 16'sd25,
      16'sd23, 16'sd19, 16'sd15, 16'sd12, 16'sd8,  16'sd6,  16'sd3,  16'sd2,
      16'sd1,  16'sd1,  16'sd0,  16'sd0,  16'sd0
   };

   // Double the sample width leaves ample headroom for 29 Q8 products.
   function automatic int acc_width(input int sample_width);
      return 2 * sample_width;
   endfunction

endpackage

// File: rtl/gaussian_fir_tap.sv
// One delay-line stage of the FIR: a sample register and its constant-coefficient product.
module gaussian_fir_tap
   import gaussian_fir_pkg::*;
#(
   parameter int    WIDTH = 32,
   parameter coef_t COEF  = '0
) (
   input  logic                              clock,
   input  logic                              nreset,
   input  logic signed [WIDTH-1:0]           x_in,
   output logic signed [WIDTH-1:0]           x_out,
   output logic signed [WIDTH+COEF_WIDTH-1:0] prod
);

   localparam int PW = WIDTH + COEF_WIDTH;

   logic signed [WIDTH-1:0] x_d;
   logic signed [WIDTH-1:0] x_q;
   logic signed [PW-1:0]    x_ext;
   logic signed [PW-1:0]    coef_ext;

   always_comb begin
      x_d = x_in;
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         x_q <= '0;
      end else begin
         x_q <= x_d;
      end
   end

   // Both operands are sign-extended first so the full-width product is exact.
   always_comb begin
      x_ext    = PW'(x_q);
      coef_ext = PW'(COEF);
      prod     = x_ext * coef_ext;
   end

   assign x_out = x_q;

endmodule

// File: rtl/gaussian_fir.sv
// 29-tap Gaussian smoothing FIR, direct form, one sample in and one registered sample out per clock.
module gaussian_fir
   import gaussian_fir_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NCOEFS = 29
) (
   input  logic                    clock,
   input  logic                    nreset,
   input  logic signed [WIDTH-1:0] xn,
   output logic signed [WIDTH-1:0] yn
);

   localparam int PW    = WIDTH + COEF_WIDTH;
   localparam int ACC_W = acc_width(WIDTH);

   if (NCOEFS != NCOEFS_FIXED) begin : g_bad_ncoefs
      $error("gaussian_fir: NCOEFS must be 29, the coefficient table is fixed");
   end

   logic signed [WIDTH-1:0] tap_in [NCOEFS];
   logic signed [WIDTH-1:0] x      [NCOEFS];
   logic signed [PW-1:0]    prod   [NCOEFS];
   logic signed [ACC_W-1:0] acc;
   logic signed [WIDTH-1:0] yn_d;
   logic signed [WIDTH-1:0] yn_q;

   assign tap_in[0] = xn;

   for (genvar k = 0; k < NCOEFS; k++) begin : g_tap
      if (k > 0) begin : g_chain
         assign tap_in[k] = x[k-1];
      end

      gaussian_fir_tap #(
         .WIDTH (WIDTH),
         .COEF  (GAUSS_COEFS[k])
      ) u_tap (
         .clock  (clock),
         .nreset (nreset),
         .x_in   (tap_in[k]),
         .x_out  (x[k]),
         .prod   (prod[k])
      );
   end

   // Arithmetic shift floors toward minus infinity; the result always fits in WIDTH.
   always_comb begin
      acc = '0;
      for (int k = 0; k < NCOEFS; k++) begin
         acc = acc + ACC_W'(prod[k]);
      end
      yn_d = WIDTH'(acc >>> COEF_FRAC);
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         yn_q <= '0;
      end else begin
         yn_q <= yn_d;
      end
   end

   assign yn = yn_q;

endmodule

// File: tb/tb_gaussian_fir.sv
// Self-checking bench for gaussian_fir: a sample-history model checked every cycle plus literal vectors.
module tb_gaussian_fir;

   localparam int WIDTH = 32;
   localparam int NTAP  = 29;

   logic                    clock;
   logic                    nreset;
   logic signed [WIDTH-1:0] xn;
   logic signed [WIDTH-1:0] yn;

   int n_vectors;
   int n_miscompares;

   // Kernel as written in the filter description, and its impulse response for a 256 input.
   int h_model [NTAP] = '{0,0,0,1,1,2,3,6,8,12,15,19,23,25,26,25,23,19,15,12,8,6,3,2,1,1,0,0,0};
   int imp_lit [NTAP] = '{0,0,0,1,1,2,3,6,8,12,15,19,23,25,26,25,23,19,15,12,8,6,3,2,1,1,0,0,0};

   longint hist [NTAP];
   longint model_yn;
   bit     model_valid;

   gaussian_fir #(
      .WIDTH  (WIDTH),
      .NCOEFS (NTAP)
   ) dut (
      .clock  (clock),
      .nreset (nreset),
      .xn     (xn),
      .yn     (yn)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: yn is the floor of the kernel-weighted sum of the previous 29 samples over 256.
   task automatic modelEdge(input longint x, input bit rst_n);
      longint sum;
      if (!rst_n) begin
         foreach (hist[k]) hist[k] = 0;
         model_yn = 0;
      end else begin
         sum = 0;
         foreach (hist[k]) sum += longint'(h_model[k]) * hist[k];
         model_yn = sum >>> 8;
         for (int k = NTAP - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = x;
      end
      model_valid = 1'b1;
   endtask

   task automatic applyStimulus(input longint x, input bit rst_n);
      @(negedge clock);
      xn     = WIDTH'(x);
      nreset = rst_n;
      @(posedge clock);
      modelEdge(x, rst_n);
      #1;
   endtask

   task automatic checkOutput(input string name, input longint expected);
      n_vectors++;
      if (yn !== WIDTH'(expected)) begin
         n_miscompares++;
         $display("[TB] FAIL %s: yn=%0d expected=%0d at %0t", name, yn, expected, $time);
      end
   endtask

   always @(negedge clock) begin
      if (model_valid) begin
         n_vectors++;
         if (yn !== WIDTH'(model_yn)) begin
            n_miscompares++;
            $display("[TB] FAIL model: yn=%0d expected=%0d at %0t", yn, model_yn, $time);
         end
      end
   end

   initial begin
      logic signed [WIDTH-1:0] prev;
      n_vectors     = 0;
      n_miscompares = 0;
      model_valid   = 1'b0;
      model_yn      = 0;
      foreach (hist[k]) hist[k] = 0;
      xn     = '0;
      nreset = 1'b0;

      // Reset holds output at zero regardless of input.
      applyStimulus(1234, 1'b0);
      applyStimulus(1234, 1'b0);
      checkOutput("reset", 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1);
      checkOutput("post_reset_idle", 0);

      // Positive impulse reproduces the kernel.
      applyStimulus(256, 1'b1);
      checkOutput("impulse_edge", 0);
      for (int k = 0; k < NTAP; k++) begin
         applyStimulus(0, 1'b1);
         checkOutput($sformatf("impulse_%0d", k), imp_lit[k]);
      end
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1);
      checkOutput("impulse_tail", 0);

      // Negative impulse is the exact negation.
      applyStimulus(-256, 1'b1);
      for (int k = 0; k < NTAP; k++) begin
         applyStimulus(0, 1'b1);
         checkOutput($sformatf("neg_impulse_%0d", k), -imp_lit[k]);
      end

      // DC step of 100: non-decreasing, exact 100 from edge 30.
      applyStimulus(0, 1'b0);
      prev = '0;
      for (int e = 1; e <= 35; e++) begin
         applyStimulus(100, 1'b1);
         if (yn < prev) checkOutput("dc100_monotonic", prev);
         prev = yn;
         if (e >= 30) checkOutput("dc100_settled", 100);
      end

      // Mid-stream reset then re-convergence 30 edges after release.
      applyStimulus(100, 1'b0);
      checkOutput("midstream_reset", 0);
      for (int e = 1; e <= 30; e++) applyStimulus(100, 1'b1);
      checkOutput("reconverge_100", 100);

      // Pulse: 0, then 100 for edges 1..29, then 10.
      applyStimulus(0, 1'b0);
      applyStimulus(0, 1'b1);
      for (int e = 1; e <= 29; e++) applyStimulus(100, 1'b1);
      applyStimulus(10, 1'b1);
      checkOutput("pulse_peak", 100);
      for (int e = 31; e <= 62; e++) begin
         applyStimulus(10, 1'b1);
         if (e >= 59) checkOutput("pulse_decay_10", 10);
      end

      // Constant -1 settles to -1 because the shift floors.
      applyStimulus(0, 1'b0);
      for (int e = 1; e <= 32; e++) begin
         applyStimulus(-1, 1'b1);
         if (e >= 30) checkOutput("dc_minus1", -1);
      end

      // Large-magnitude mixed samples exercise the model without overflow.
      for (int i = 0; i < 40; i++) applyStimulus(((i % 3) == 0) ? -2000000000 : 1999999999, 1'b1);

      @(negedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
